// File: rtl/bru_bpred.sv
// Branch resolver with registered redirect plus a direct-mapped BTB predictor.
// Optional statistics counters are enabled with `define BPRED_STATS_EN.
module bru_bpred #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [7:0]      ex_type,
  input  logic [XLEN-1:0] ex_src1,
  input  logic [XLEN-1:0] ex_src2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_taken,
  output logic [XLEN-1:0] ex_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int N = 1 << IDX_W;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  // Valid semantics: if_valid and ex_valid are single-cycle qualifiers with no
  // backpressure; pred_valid and redirect are one-cycle registered responses.

  logic             v_q   [N];
  logic [TAG_W-1:0] tag_q [N];
  logic [XLEN-1:0]  tgt_q [N];
  logic [1:0]       ctr_q [N];
  logic             jmp_q [N];

  logic            pred_valid_q, pred_valid_d;
  logic            pred_taken_q, pred_taken_d;
  logic [XLEN-1:0] pred_target_q, pred_target_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  // Fetch-side lookup
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             lk_hit, lk_taken;
  assign if_idx   = if_pc[IDX_W+1:2];
  assign if_tag   = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit   = v_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign lk_taken = lk_hit && (jmp_q[if_idx] || ctr_q[if_idx][1]);

  always_comb begin
    pred_valid_d  = if_valid;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (if_valid) begin
      pred_taken_d  = lk_taken;
      pred_target_d = lk_taken ? tgt_q[if_idx] : if_pc + FOUR;
    end
  end

  // Execute-side resolve
  logic [XLEN:0]   diff;
  logic            cout, lt, ltu, eq, is_br, is_jump, cond, mispred;
  logic [XLEN-1:0] jalr_sum;
  assign diff     = {1'b0, ex_src1} + {1'b0, ~ex_src2} + {{XLEN{1'b0}}, 1'b1};
  assign cout     = diff[XLEN];
  assign lt       = (ex_src1[XLEN-1] & ~ex_src2[XLEN-1]) |
                    (~(ex_src1[XLEN-1] ^ ex_src2[XLEN-1]) & diff[XLEN-1]);
  assign ltu      = ~cout;
  assign eq       = (diff[XLEN-1:0] == '0);
  assign is_br    = ex_valid && (ex_type != 8'd0);
  assign is_jump  = ex_type[0] | ex_type[1];
  assign jalr_sum = ex_src1 + ex_imm;

  always_comb begin
    cond = (ex_type[0] | ex_type[1]) |
           (ex_type[2] & eq)  | (ex_type[3] & ~eq) |
           (ex_type[4] & lt)  | (ex_type[5] & ~lt) |
           (ex_type[6] & ltu) | (ex_type[7] & ~ltu);
    ex_taken  = is_br && cond;
    ex_target = ex_type[1] ? {jalr_sum[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
  end

  assign mispred = is_br && ((ex_taken != ex_pred_taken) ||
                             (ex_taken && (ex_target != ex_pred_target)));

  always_comb begin
    redirect_d    = mispred;
    redirect_pc_d = redirect_pc_q;
    if (mispred) redirect_pc_d = ex_taken ? ex_target : ex_pc + FOUR;
  end

  // Table update, indexed by the resolving PC
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [1:0]       ctr_cur, ctr_upd;
  assign ex_idx  = ex_pc[IDX_W+1:2];
  assign ex_tag  = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_hit  = v_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ctr_cur = ctr_q[ex_idx];

  always_comb begin
    ctr_upd = ctr_cur;
    if (is_jump)                         ctr_upd = 2'b11;
    else if (ex_taken && ctr_cur != 2'b11) ctr_upd = ctr_cur + 2'd1;
    else if (!ex_taken && ctr_cur != 2'b00) ctr_upd = ctr_cur - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        v_q[i]   <= 1'b0;
        ctr_q[i] <= 2'b01;
      end
    end else if (is_br) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_upd;
        if (ex_taken) tgt_q[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        v_q[ex_idx]   <= 1'b1;
        tag_q[ex_idx] <= ex_tag;
        tgt_q[ex_idx] <= ex_target;
        ctr_q[ex_idx] <= is_jump ? 2'b11 : 2'b10;
        jmp_q[ex_idx] <= is_jump;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

`ifdef BPRED_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (is_br)   stat_br_q <= stat_br_q + 32'd1;
      if (mispred) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end
  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;
`endif

  // PC bits outside the index/tag fields and the jalr lsb do not matter
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], if_pc[XLEN-1:IDX_W+TAG_W+2],
                         ex_pc[1:0], ex_pc[XLEN-1:IDX_W+TAG_W+2], jalr_sum[0]};

endmodule

// File: tb/tb_bru_bpred.sv
// Directed bench for bru_bpred: lookup, resolve, redirect, counter training,
// aliasing, read-before-write and mid-run reset.
module tb_bru_bpred;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [7:0]  ex_type;
  logic [31:0] ex_src1, ex_src2, ex_pc, ex_imm;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [7:0] T_JAL = 8'h01, T_JALR = 8'h02, T_BEQ = 8'h04, T_BNE = 8'h08,
                         T_BLT = 8'h10, T_BGE = 8'h20, T_BLTU = 8'h40, T_BGEU = 8'h80;

  bru_bpred dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_type(ex_type),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    if_valid = 1'b0;
    ex_valid = 1'b0;
  endtask

  task automatic resolve(input logic [7:0] t, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_type = t; ex_src1 = s1; ex_src2 = s2;
    ex_pc = pc; ex_imm = imm; ex_pred_taken = pt; ex_pred_target = ptgt;
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    ex_valid = 1'b0; if_valid = 1'b1; if_pc = pc;
    tick();
    if_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_valid = 0; if_pc = 0; ex_valid = 0; ex_type = 0;
    ex_src1 = 0; ex_src2 = 0; ex_pc = 0; ex_imm = 0; ex_pred_taken = 0; ex_pred_target = 0;
    tick(); tick();
    rst = 1'b0;
    check("rst_pred_valid", pred_valid, 0);
    check("rst_pred_taken", pred_taken, 0);
    check("rst_pred_target", pred_target, 0);
    check("rst_redirect", redirect, 0);
    check("rst_redirect_pc", redirect_pc, 0);

    // cold lookup misses; idle cycle holds outputs
    lookup(32'h8000_0000);
    check("cold_pv", pred_valid, 1);
    check("cold_pt", pred_taken, 0);
    check("cold_ptgt", pred_target, 32'h8000_0004);
    tick();
    check("idle_pv", pred_valid, 0);
    check("idle_hold_ptgt", pred_target, 32'h8000_0004);

    // beq taken, predicted not taken -> redirect and allocate
    resolve(T_BEQ, 5, 5, 32'h8000_0010, 32'h20, 0, 0);
    check("beq_taken", ex_taken, 1);
    check("beq_target", ex_target, 32'h8000_0030);
    tick();
    check("beq_redirect", redirect, 1);
    check("beq_redirect_pc", redirect_pc, 32'h8000_0030);
    lookup(32'h8000_0010);
    check("redirect_one_cycle", redirect, 0);
    check("alloc_pt", pred_taken, 1);
    check("alloc_ptgt", pred_target, 32'h8000_0030);

    // compare flavours, combinational only
    resolve(T_BLT, 32'hFFFF_FFFF, 1, 32'h8000_0200, 8, 0, 0);
    check("blt", ex_taken, 1);
    resolve(T_BGE, 32'hFFFF_FFFF, 1, 32'h8000_0200, 8, 0, 0);
    check("bge", ex_taken, 0);
    resolve(T_BLTU, 32'hFFFF_FFFF, 1, 32'h8000_0200, 8, 0, 0);
    check("bltu", ex_taken, 0);
    resolve(T_BGEU, 32'hFFFF_FFFF, 1, 32'h8000_0200, 8, 0, 0);
    check("bgeu", ex_taken, 1);
    check("bgeu_target", ex_target, 32'h8000_0208);
    resolve(T_BLTU, 1, 32'hFFFF_FFFF, 32'h8000_0200, 8, 0, 0);
    check("bltu_small", ex_taken, 1);
    ex_valid = 1'b0; ex_type = T_BEQ; ex_src1 = 3; ex_src2 = 3; #1;
    check("gated_by_valid", ex_taken, 0);
    resolve(T_BNE, 7, 7, 32'h8000_0200, 8, 0, 0);
    check("bne_equal", ex_taken, 0);
    tick();
    idle();
    check("bne_no_redirect", redirect, 0);

    // jalr clears lsb; wrong predicted target -> redirect
    resolve(T_JALR, 32'h8000_1003, 1, 32'h8000_0300, 0, 1, 32'h8000_1000);
    check("jalr_taken", ex_taken, 1);
    check("jalr_target", ex_target, 32'h8000_1002);
    tick();
    idle();
    check("jalr_redirect", redirect, 1);
    check("jalr_redirect_pc", redirect_pc, 32'h8000_1002);

    // counter training on entry at 0x80000010 (ctr=10)
    resolve(T_BEQ, 1, 2, 32'h8000_0010, 32'h20, 1, 32'h8000_0030);
    tick();
    check("nt_redirect", redirect, 1);
    check("nt_redirect_pc", redirect_pc, 32'h8000_0014);
    resolve(T_BEQ, 1, 2, 32'h8000_0010, 32'h20, 0, 0);
    tick();
    lookup(32'h8000_0010);
    check("ctr00_pt", pred_taken, 0);
    check("ctr00_ptgt", pred_target, 32'h8000_0014);
    resolve(T_BEQ, 4, 4, 32'h8000_0010, 32'h20, 0, 0);
    tick();
    lookup(32'h8000_0010);
    check("ctr01_pt", pred_taken, 0);
    resolve(T_BEQ, 4, 4, 32'h8000_0010, 32'h20, 0, 0);
    tick();
    lookup(32'h8000_0010);
    check("ctr10_pt", pred_taken, 1);
    resolve(T_BEQ, 4, 4, 32'h8000_0010, 32'h20, 1, 32'h8000_0030);
    tick();
    resolve(T_BEQ, 4, 4, 32'h8000_0010, 32'h20, 1, 32'h8000_0030);
    tick();
    idle();
    check("correct_pred_no_redirect", redirect, 0);
    resolve(T_BEQ, 1, 2, 32'h8000_0010, 32'h20, 1, 32'h8000_0030);
    tick();
    lookup(32'h8000_0010);
    check("sat11_then_nt_pt", pred_taken, 1);
    check("sat11_ptgt", pred_target, 32'h8000_0030);
    resolve(T_BEQ, 1, 2, 32'h8000_0010, 32'h20, 1, 32'h8000_0030);
    tick();
    lookup(32'h8000_0010);
    check("ctr01_again_pt", pred_taken, 0);

    // aliasing: same index, different tag
    lookup(32'h8000_0110);
    check("alias_pt", pred_taken, 0);
    check("alias_ptgt", pred_target, 32'h8000_0114);

    // read-before-write on the jalr entry (idx 0)
    if_valid = 1'b1; if_pc = 32'h8000_0300;
    resolve(T_JAL, 0, 0, 32'h8000_0300, 32'h40, 0, 0);
    tick();
    idle();
    check("rbw_pt", pred_taken, 1);
    check("rbw_old_tgt", pred_target, 32'h8000_1002);
    lookup(32'h8000_0300);
    check("rbw_new_tgt", pred_target, 32'h8000_0340);

    // reset during a pending redirect
    lookup(32'h8000_0010);
    resolve(T_BNE, 1, 2, 32'h8000_0010, 32'h20, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("rst_drop_redirect", redirect, 0);
    check("rst_drop_redirect_pc", redirect_pc, 0);
    check("rst_mid_pv", pred_valid, 0);
    lookup(32'h8000_0010);
    check("post_rst_miss_pt", pred_taken, 0);
    check("post_rst_miss_ptgt", pred_target, 32'h8000_0014);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
